fifo_tx_serializer: RTL
=======================

Name: fifo_tx_serializer

Overview:
Downstream drain stage for the 16x8 shift-register FIFO. Pops one byte at a time through the FIFO read handshake and transmits it on a single-wire, UART-style serial line: start bit, LSB-first data, optional even parity, stop bit. It is the FIFO's only consumer, and its fifo_empty input is wired to the FIFO underflow flag.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 2..255.
DATA_W, 8, data width; must match the FIFO word width.
PARITY_EN, 0, 1 inserts an even-parity bit between the last data bit and the stop bit.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-low reset, sampled on rising clk.
enable  input  1  1 permits new FIFO pops; a frame in progress always completes.
fifo_empty  input  1  FIFO underflow/empty flag; 1 means do not read.
fifo_data  input  DATA_W  FIFO data_out; registered by the FIFO.
fifo_rd  output  1  FIFO read enable (en_read); registered, single-cycle pulse.
tx  output  1  serial line; idles high.
busy  output  1  high from the fifo_rd cycle through the end of the stop bit.
byte_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE, tx=1, fifo_rd=0, busy=0, byte_done=0, shift register=0, bit and baud counters=0. Reset overrides every state, mid-frame included; tx returns to 1 at the same edge.
- FSM states: IDLE, READ, CAPTURE, START, DATA, PARITY, STOP.
- IDLE: if enable==1 and fifo_empty==0 -> READ. Otherwise stay in IDLE.
- READ: fifo_rd=1 for exactly this one cycle; busy=1. Next state is always CAPTURE.
- CAPTURE: the FIFO presents the popped byte this cycle. Load fifo_data into the shift register and compute parity = XOR of the data bits. fifo_rd=0. Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. Bit counter runs 0..DATA_W-1. Exit to PARITY if PARITY_EN, else to STOP.
- PARITY: tx=parity for CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles. byte_done=1 in the final cycle. Next state is IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and clears on every bit boundary. Counter width is 8 bits; there is no wrap beyond CLKS_PER_BIT-1.
- Latency: fifo_rd is asserted one cycle after the IDLE condition is met. tx falls two cycles after fifo_rd.
- Frame length is (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles, plus 2 cycles (READ, CAPTURE), plus at least 1 IDLE cycle.
- Back-to-back pops are separated by at least one IDLE cycle. This guarantees the FIFO's one-cycle-late empty flag has settled before it is re-sampled.
- fifo_empty and enable are ignored outside IDLE. Deasserting enable mid-frame does not truncate the frame.
- fifo_empty==1 in IDLE: no fifo_rd is ever issued. No read occurs on an empty FIFO.
- busy=1 in every state except IDLE.
- tx is driven from a register, so it is glitch-free.

Test Plan:
- Basic frame: CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds 0xA5, enable=1 -> exactly one fifo_rd pulse. tx sequence is 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles. byte_done pulses in cycle 40 after tx falls. busy=0 the cycle after.
- Empty FIFO: fifo_empty=1, enable=1 for 100 cycles -> fifo_rd stays 0, tx stays 1, busy stays 0.
- Back-to-back: FIFO holds 0x00 then 0xFF -> two fifo_rd pulses exactly 43 cycles apart (40 frame + READ + CAPTURE + 1 IDLE). Data bits are all 0 for the first frame and all 1 for the second. After the second frame, fifo_empty=1 and no third pop occurs.
- Parity: PARITY_EN=1, byte 0xA5 -> parity bit 0. Byte 0x07 -> parity bit 1. byte_done pulses in cycle 44 after tx falls.
- Enable drop: deassert enable during DATA bit 3 -> current frame completes unchanged and no further fifo_rd pulse occurs while enable=0. Re-asserting enable with a byte pending -> fifo_rd pulses the cycle after.
- Reset mid-frame: drive reset=0 for 1 cycle during DATA -> at that edge tx=1, busy=0, fifo_rd=0. The byte is dropped and no new read occurs until reset=1 and the IDLE condition is met.

Source files
------------

// File: rtl/fifo_tx_serializer.sv
// -----------------------------------------------------------------------------
// fifo_tx_serializer
//
// Drain stage for the shift-register FIFO. Pops one word through the FIFO read
// handshake and sends it on a UART-style serial line: one start bit (0), the
// data bits LSB first, an optional even-parity bit, and one stop bit (1). Each
// bit is held for CLKS_PER_BIT clocks.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous active-low reset
//   enable      1 permits new FIFO pops; a frame already started always completes
//   fifo_empty  FIFO empty/underflow flag; no pop is issued while it is 1
//   fifo_data   FIFO registered output word, valid the cycle after fifo_rd
//   fifo_rd     single-cycle FIFO read pulse (registered)
//   tx          serial line, idles high (registered, glitch-free)
//   busy        high from the fifo_rd cycle through the end of the stop bit
//   byte_done   one-cycle pulse in the final cycle of the stop bit
// -----------------------------------------------------------------------------
module fifo_tx_serializer #(
  parameter int CLKS_PER_BIT = 4,  // 2..255
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int               BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0]       BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state, state_next;
  logic [7:0]        baud, baud_next;
  logic [BIT_W-1:0]  bit_cnt, bit_next;
  logic [DATA_W-1:0] shift, shift_next;
  logic              parity, parity_next;
  logic              tx_next, rd_next, busy_next, done_next;
  logic              baud_last;

  assign baud_last = (baud == BAUD_LAST);

  // All outputs are computed from the state being entered and registered, so
  // tx/fifo_rd/busy/byte_done change exactly on the edge that changes state.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next  = state;
    baud_next   = baud;
    bit_next    = bit_cnt;
    shift_next  = shift;
    parity_next = parity;

    case (state)
      S_IDLE: begin
        if (enable && !fifo_empty) state_next = S_READ;
      end
      S_READ: begin
        state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        // The FIFO's registered output holds the popped word this cycle.
        shift_next  = fifo_data;
        parity_next = ^fifo_data;
        baud_next   = '0;
        bit_next    = '0;
        state_next  = S_START;
      end
      S_START: begin
        if (baud_last) begin
          baud_next  = '0;
          state_next = S_DATA;
        end else begin
          baud_next = baud + 8'd1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_next  = '0;
          shift_next = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_next   = '0;
            state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end else begin
          baud_next = baud + 8'd1;
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          baud_next  = '0;
          state_next = S_STOP;
        end else begin
          baud_next = baud + 8'd1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_next  = '0;
          state_next = S_IDLE;
        end else begin
          baud_next = baud + 8'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
      S_PARITY: tx_next = parity_next;
      default:  tx_next = 1'b1;
    endcase

    rd_next   = (state_next == S_READ);
    busy_next = (state_next != S_IDLE);
    done_next = (state_next == S_STOP) && (baud_next == BAUD_LAST);
  end

  // Synchronous reset returns everything, mid-frame included, to idle; the
  // popped word in the shift register is discarded.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state     <= S_IDLE;
      baud      <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      parity    <= 1'b0;
      tx        <= 1'b1;
      fifo_rd   <= 1'b0;
      busy      <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      state     <= state_next;
      baud      <= baud_next;
      bit_cnt   <= bit_next;
      shift     <= shift_next;
      parity    <= parity_next;
      tx        <= tx_next;
      fifo_rd   <= rd_next;
      busy      <= busy_next;
      byte_done <= done_next;
    end
  end

endmodule
